// File: rtl/lane_code_sequencer.sv
// lane_code_sequencer
// Feeds the 4-to-16 lane decoder: accepts a dispatch job (start lane, lane
// count, lane-enable mask) and emits one lane code per handshake, visiting
// enabled lanes in rotating order from the start lane and wrapping mod LANES.
// Optional feature macro: LANE_SEQ_PERF_EN enables the backpressure stall
// counter on perf_stall_cnt; without it the port reads constant zero.
module lane_code_sequencer #(
    parameter int CODE_W = 4,
    parameter int LEN_W  = 5,
    localparam int LANES = 2**CODE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [CODE_W-1:0] job_first,
    input  logic [LEN_W-1:0]  job_len,
    input  logic [LANES-1:0]  job_mask,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              code_last,
    output logic              done,
    output logic              busy,
    output logic [15:0]       perf_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [LANES-1:0]   r_pending;
    logic [CODE_W-1:0]  r_code;
    logic               r_codeValid;
    logic               r_codeLast;
    logic               r_done;
    logic               r_busy;
    logic               r_jobReady;

    logic               w_accept;
    logic               w_handshake;
    logic [LEN_W-1:0]   w_effLen;
    logic [LANES-1:0]   w_window;
    logic [LANES-1:0]   w_acceptPending;
    logic [LANES-1:0]   w_clearMask;
    logic [LANES-1:0]   w_afterPending;
    logic [LANES-1:0]   w_searchPending;
    logic [CODE_W-1:0]  w_searchPtr;
    logic [CODE_W-1:0]  w_foundCode;
    logic               w_searchSingle;

    assign w_accept    = job_valid && r_jobReady;
    assign w_handshake = r_codeValid && code_ready;

    // Lengths beyond the lane count cover every lane exactly once.
    assign w_effLen = (job_len > LEN_W'(LANES)) ? LEN_W'(LANES) : job_len;

    // Build the rotating window of lanes first .. first+len-1 (mod LANES).
    always_comb begin
        w_window = '0;
        for (int k = 0; k < LANES; k++) begin
            if (k < int'(w_effLen)) begin
                w_window[job_first + CODE_W'(k)] = 1'b1;
            end
        end
    end

    assign w_acceptPending = job_mask & w_window;
    assign w_clearMask     = LANES'(1) << r_code;
    assign w_afterPending  = r_pending & ~w_clearMask;

    // The scan pointer is never stored: it is job_first at accept time and
    // code+1 after a handshake, which are exactly the two moments a search
    // result is needed, so a single search serves both.
    assign w_searchPending = (r_state == ST_IDLE) ? w_acceptPending : w_afterPending;
    assign w_searchPtr     = (r_state == ST_IDLE) ? job_first : r_code + 1'b1;

    // Find the first pending lane at or after the pointer, wrapping around.
    always_comb begin
        logic [CODE_W-1:0] idx;
        idx         = '0;
        w_foundCode = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            idx = w_searchPtr + CODE_W'(i);
            if (w_searchPending[idx]) begin
                w_foundCode = idx;
            end
        end
    end

    assign w_searchSingle = (w_searchPending != '0) &&
                            ((w_searchPending & (w_searchPending - LANES'(1))) == '0);

    // Job FSM with registered code/handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pending   <= '0;
            r_code      <= '0;
            r_codeValid <= 1'b0;
            r_codeLast  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_jobReady  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pending  <= w_acceptPending;
                        r_jobReady <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_acceptPending != '0) begin
                            r_state     <= ST_RUN;
                            r_code      <= w_foundCode;
                            r_codeValid <= 1'b1;
                            r_codeLast  <= w_searchSingle;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_handshake) begin
                        r_pending <= w_afterPending;
                        if (w_afterPending == '0) begin
                            r_state     <= ST_DONE;
                            r_codeValid <= 1'b0;
                            r_codeLast  <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_code     <= w_foundCode;
                            r_codeLast <= w_searchSingle;
                        end
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_jobReady <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign job_ready  = r_jobReady;
    assign code       = r_code;
    assign code_valid = r_codeValid;
    assign code_last  = r_codeLast;
    assign done       = r_done;
    assign busy       = r_busy;

`ifdef LANE_SEQ_PERF_EN
    logic [15:0] r_stallCnt;

    // Count backpressured cycles per job, saturating, cleared on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (w_accept) begin
            r_stallCnt <= '0;
        end else if (r_codeValid && !code_ready && (r_stallCnt != 16'hFFFF)) begin
            r_stallCnt <= r_stallCnt + 16'd1;
        end
    end

    assign perf_stall_cnt = r_stallCnt;
`else
    assign perf_stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_lane_code_sequencer.sv
// tb_lane_code_sequencer
// Directed bench for lane_code_sequencer with hand-computed lane sequences.
// Compile with +define+LANE_SEQ_PERF_EN to expect a live stall counter.
module tb_lane_code_sequencer;

    localparam int CODE_W = 4;
    localparam int LEN_W  = 5;
    localparam int LANES  = 16;

`ifdef LANE_SEQ_PERF_EN
    localparam logic [15:0] PERF_EXP = 16'd3;
`else
    localparam logic [15:0] PERF_EXP = 16'd0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              job_valid;
    logic              job_ready;
    logic [CODE_W-1:0] job_first;
    logic [LEN_W-1:0]  job_len;
    logic [LANES-1:0]  job_mask;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              code_ready;
    logic              code_last;
    logic              done;
    logic              busy;
    logic [15:0]       perf_stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    lane_code_sequencer #(
        .CODE_W(CODE_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_first     (job_first),
        .job_len       (job_len),
        .job_mask      (job_mask),
        .code          (code),
        .code_valid    (code_valid),
        .code_ready    (code_ready),
        .code_last     (code_last),
        .done          (done),
        .busy          (busy),
        .perf_stall_cnt(perf_stall_cnt)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a job for one cycle; returns in the cycle after the accept edge.
    task automatic applyStimulus(input logic [CODE_W-1:0] first,
                                 input logic [LEN_W-1:0] len,
                                 input logic [LANES-1:0] mask);
        job_first = first;
        job_len   = len;
        job_mask  = mask;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
    endtask

    task automatic checkCode(input string tag, input logic [CODE_W-1:0] expCode,
                             input logic expLast);
        checkOutput({tag, "_valid"}, code_valid, 1);
        checkOutput({tag, "_code"}, code, expCode);
        checkOutput({tag, "_last"}, code_last, expLast);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Called in the DONE cycle; also checks the return to IDLE one cycle later.
    task automatic checkDone(input string tag);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_cvalid"}, code_valid, 0);
        checkOutput({tag, "_busy"}, busy, 1);
        checkOutput({tag, "_jready0"}, job_ready, 0);
        tick();
        checkOutput({tag, "_jready1"}, job_ready, 1);
        checkOutput({tag, "_doneoff"}, done, 0);
        checkOutput({tag, "_idlebusy"}, busy, 0);
    endtask

    initial begin
        logic [CODE_W-1:0] seq2 [4];
        logic [CODE_W-1:0] seq3 [4];
        seq2 = '{4'd14, 4'd15, 4'd0, 4'd1};
        seq3 = '{4'd0, 4'd2, 4'd5, 4'd7};

        rst_n      = 1'b0;
        job_valid  = 1'b0;
        job_first  = '0;
        job_len    = '0;
        job_mask   = '0;
        code_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_jready", job_ready, 1);
        checkOutput("rst_code", code, 0);
        checkOutput("rst_cvalid", code_valid, 0);
        checkOutput("rst_last", code_last, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_perf", perf_stall_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Full sweep of all 16 lanes from lane 0.
        applyStimulus(4'd0, 5'd16, 16'hFFFF);
        checkOutput("t1_busy", busy, 1);
        for (int k = 0; k < 16; k++) begin
            checkCode("t1", CODE_W'(k), (k == 15));
            tick();
        end
        checkDone("t1");

        // Window wrapping past lane 15.
        applyStimulus(4'd14, 5'd4, 16'hFFFF);
        for (int k = 0; k < 4; k++) begin
            checkCode("t2", seq2[k], (k == 3));
            tick();
        end
        checkDone("t2");

        // Sparse mask; a second job request held during RUN must be ignored.
        applyStimulus(4'd0, 5'd8, 16'h00A5);
        job_first = 4'd9;
        job_len   = 5'd3;
        job_mask  = 16'hFFFF;
        job_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkCode("t3", seq3[k], (k == 3));
            checkOutput("t3_jready", job_ready, 0);
            if (k == 3) job_valid = 1'b0;
            tick();
        end
        checkDone("t3");

        // Backpressure: hold ready low three cycles while code 2 is shown.
        applyStimulus(4'd0, 5'd4, 16'hFFFF);
        checkCode("t4a", 4'd0, 1'b0);
        tick();
        checkCode("t4b", 4'd1, 1'b0);
        tick();
        checkCode("t4c", 4'd2, 1'b0);
        code_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkCode("t4hold", 4'd2, 1'b0);
        end
        code_ready = 1'b1;
        tick();
        checkCode("t4d", 4'd3, 1'b1);
        tick();
        checkOutput("t4_perf_done", perf_stall_cnt, PERF_EXP);
        checkDone("t4");
        checkOutput("t4_perf_hold", perf_stall_cnt, PERF_EXP);

        // Empty jobs: zero length, then an all-disabled mask.
        applyStimulus(4'd3, 5'd0, 16'hFFFF);
        checkOutput("t5a_perfclr", perf_stall_cnt, 0);
        checkDone("t5a");
        applyStimulus(4'd3, 5'd4, 16'h0000);
        checkDone("t5b");

        // Oversized length clamps to a single pass; wraps from 12 to 4.
        applyStimulus(4'd12, 5'd20, 16'h1010);
        checkCode("t7a", 4'd12, 1'b0);
        tick();
        checkCode("t7b", 4'd4, 1'b1);
        tick();
        checkDone("t7");

        // Reset in the middle of a job drops it without a done pulse.
        applyStimulus(4'd0, 5'd16, 16'hFFFF);
        for (int k = 0; k < 5; k++) tick();
        checkCode("t6pre", 4'd5, 1'b0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t6_cvalid", code_valid, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_jready", job_ready, 1);
        checkOutput("t6_done", done, 0);
        tick();
        checkOutput("t6_done2", done, 0);
        checkOutput("t6_cvalid2", code_valid, 0);
        applyStimulus(4'd3, 5'd2, 16'hFFFF);
        checkCode("t6n_a", 4'd3, 1'b0);
        tick();
        checkCode("t6n_b", 4'd4, 1'b1);
        tick();
        checkDone("t6n");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lane_code_sequencer.md
Name: lane_code_sequencer

Overview:
Upstream feeder for the 4-to-16 lane decoder in the accelerator datapath. It accepts a dispatch job (start lane, lane count, lane-enable mask) and emits one 4-bit lane code per handshake. Codes go in rotating order, wrapping modulo LANES, and disabled lanes are skipped at no cost. The downstream decoder turns each emitted code into the one-hot lane select for PE write or compute enables.

Parameters:
CODE_W, 4, lane code width; LANES = 2**CODE_W (16 by default)
LEN_W, 5, width of job_len; must hold the value LANES

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
job_valid  input  1  job request
job_ready  output  1  high only in IDLE; job accepted when job_valid && job_ready
job_first  input  CODE_W  starting lane
job_len  input  LEN_W  window length in lanes; values > LANES clamp to LANES
job_mask  input  LANES  lane enable, bit i = lane i
code  output  CODE_W  lane code to decoder
code_valid  output  1  code is valid
code_ready  input  1  downstream accepts code
code_last  output  1  qualifies the final code of the job
done  output  1  one-cycle pulse at job completion
busy  output  1  high in RUN and DONE states
perf_stall_cnt  output  16  stall counter (see Optional Feature)

Behaviour:
- Interface: clock port is clk; reset port is rst_n, synchronous, active-low; one clock domain.
- Reset values: job_ready=1, code=0, code_valid=0, code_last=0, done=0, busy=0, perf_stall_cnt=0. Reset clears pending/pointer and returns the FSM to IDLE.
- FSM states and transitions:
  - IDLE -> RUN on job accept when pending is non-empty.
  - IDLE -> DONE on job accept when pending is empty.
  - RUN -> DONE on handshake of the last code.
  - DONE -> IDLE after one cycle; done=1 during DONE.
- On accept, latch pending[LANES-1:0] = job_mask AND window.
  - window = set of lanes (job_first + k) mod LANES, for k = 0..min(job_len,LANES)-1.
  - Set pointer ptr = job_first.
- In RUN:
  - code = first set bit of pending, searching from ptr upward and wrapping mod LANES.
  - code_valid=1.
  - code_last = (popcount(pending)==1).
- Handshake (code_valid && code_ready):
  - clear pending[code]; set ptr = code+1 mod LANES.
  - Next code is presented the following cycle, so one code per cycle under continuous ready.
- Latency: accept at cycle T -> first code_valid at T+1.
  - Last handshake at cycle L -> done=1 at L+1, job_ready=1 at L+2.
  - Empty job: done at T+1, no code_valid.
- Backpressure: while code_valid && !code_ready, code and code_last are held stable and code_valid stays high.
- code, code_valid and code_last are registered outputs. No combinational path from code_ready to code_valid.
- job inputs are ignored outside IDLE. job_len=0 produces an empty job.
- Reset mid-job: the next cycle shows reset values and the job is dropped; done is not asserted.

Optional Feature:
LANE_SEQ_PERF_EN
- Defined: perf_stall_cnt counts cycles with code_valid && !code_ready. It saturates at 16'hFFFF, clears to 0 on job accept, and holds its value after done.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is present. The port is always present.

Test Plan:
1. first=0, len=16, mask=16'hFFFF, code_ready=1 -> codes 0..15 on cycles T+1..T+16; code_last only with 15; done at T+17.
2. first=14, len=4, mask=16'hFFFF -> codes 14,15,0,1 back-to-back; code_last with 1.
3. first=0, len=8, mask=16'h00A5 -> codes 0,2,5,7 on consecutive cycles; code_last with 7; done 5 cycles after accept.
4. first=0, len=4, mask=16'hFFFF, code_ready low for 3 cycles while code=2 -> code stays 2 with code_valid=1; sequence resumes with 3; perf_stall_cnt=3 with LANE_SEQ_PERF_EN, else 0.
5. len=0, and separately len=4 with mask=0 -> no code_valid; done at T+1; job_ready=1 at T+2.
6. rst_n=0 for one cycle during RUN at code=5 -> next cycle code_valid=0, busy=0, job_ready=1, no done; new job then starts cleanly.
